icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter IndexWidth, 7, log2 of entry count (128 direct-mapped one-word entries).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 instEn  input  1  fetch lookup request, level, valid in the current cycle.
REQ-005 instAddr  input  32  fetch instruction address; bits [1:0] ignored.
REQ-006 flush  input  1  one-cycle pulse; invalidates every entry (fence.i).
REQ-007 hit  output  1  lookup hit, combinational, same cycle as instEn.
REQ-008 cacheInst  output  32  instruction word for a hit; don't-care when hit=0.
REQ-009 memReqEn  output  1  registered one-cycle miss request to memory controller.
REQ-010 memReqAddr  output  32  registered miss address, word-aligned, held until fill.
REQ-011 memInstOutEn  input  1  memory returns the requested word this cycle.
REQ-012 memInst  input  32  returned instruction word.

Function
REQ-013 Index = instAddr[IndexWidth+1:2]; tag = instAddr[31:IndexWidth+2]; storage per entry: valid bit, tag, 32-bit word.
REQ-014 hit SHALL be 1 iff instEn=1, state=IDLE, memInstOutEn=0, valid[index]=1 and stored tag equals address tag.
REQ-015 cacheInst SHALL equal the data word at index, regardless of hit.
REQ-016 FSM states: IDLE, MISS.
REQ-017 IDLE, instEn=1, hit=0, flush=0: next edge -> MISS, memReqEn=1 for exactly one cycle, memReqAddr={instAddr[31:2],2'b00}, drop=0.
REQ-018 IDLE otherwise: stay IDLE, memReqEn=0.
REQ-019 MISS: hit forced 0 and new requests ignored; memReqEn=0; memReqAddr held.
REQ-020 MISS, memInstOutEn=1: next edge -> IDLE; if drop=0 and flush=0, entry at memReqAddr index written valid with memReqAddr tag and memInst.
REQ-021 Fill overwrites any previous entry at that index (direct-mapped replacement, no write-back).
REQ-022 flush=1: all valid bits cleared at next edge; if state=MISS (or entering MISS that edge) drop set to 1 so the in-flight fill is discarded; flush wins over a same-cycle fill.
REQ-023 Fetch redirect while in MISS: outstanding fill still completes and is written to its latched address; lookups resume in IDLE the cycle after fill.
REQ-024 memInstOutEn in IDLE SHALL be ignored (no write, no state change).
REQ-025 Latency: hit 0 cycles; miss request issued 1 cycle after missing lookup; line usable by hit 1 cycle after memInstOutEn.

Reset
REQ-026 rst=0 asynchronously: state=IDLE, all valid bits 0, drop=0, memReqEn=0, memReqAddr=0, hit=0; tag/data arrays need not be reset.
REQ-027 Reset mid-MISS abandons the request; a later memInstOutEn in IDLE is ignored per REQ-024.
REQ-028 First lookup after rst release SHALL miss.

Verification
REQ-029 Cold miss: release rst, instEn=1 addr 0x00000000 -> hit=0, next cycle memReqEn=1 addr 0x0; memInstOutEn with 0x00000013 -> one cycle later lookup 0x0 gives hit=1, cacheInst=0x00000013.
REQ-030 Conflict: fill 0x00000000 then 0x00000200 (same index, IndexWidth=7) -> lookup 0x0 misses, 0x200 hits.
REQ-031 Flush during MISS: miss on 0x4, flush pulse, memInstOutEn with 0x12345678 -> lookup 0x4 misses again, memReqEn reissued.
REQ-032 Flush and fill same cycle on 0x8 -> entry not valid; lookup 0x8 misses.
REQ-033 Reset mid-MISS: miss on 0xC, assert rst for 1 cycle, release -> memReqEn=0, hit=0 for 0xC, stray memInstOutEn causes no write.
REQ-034 Back-to-back hits: 0x0,0x4,0x8 all filled, instEn held with stepping addr -> hit=1 each cycle, memReqEn stays 0.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-entry instruction cache with a single outstanding miss.
// Lookups are combinational. A miss issues one registered request, and the returned word fills the entry.
module icache #(
  parameter int unsigned IndexWidth = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instEn,
  input  logic [31:0] instAddr,
  input  logic        flush,
  output logic        hit,
  output logic [31:0] cacheInst,
  output logic        memReqEn,
  output logic [31:0] memReqAddr,
  input  logic        memInstOutEn,
  input  logic [31:0] memInst
);

  localparam int unsigned Entries  = 1 << IndexWidth;
  localparam int unsigned TagWidth = 32 - IndexWidth - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                r_state;
  logic                  r_drop;
  logic                  r_req_en;
  logic [31:0]           r_req_addr;
  logic [Entries-1:0]    r_valid;
  logic [TagWidth-1:0]   r_tag  [Entries];
  logic [31:0]           r_data [Entries];

  logic [IndexWidth-1:0] w_index;
  logic [IndexWidth-1:0] w_fill_index;
  logic [TagWidth-1:0]   w_tag;
  logic [TagWidth-1:0]   w_fill_tag;
  logic                  w_miss;
  logic                  w_fill;
  logic                  w_unused_addr_lsbs;

  assign w_index      = instAddr[IndexWidth+1:2];
  assign w_tag        = instAddr[31:IndexWidth+2];
  assign w_fill_index = r_req_addr[IndexWidth+1:2];
  assign w_fill_tag   = r_req_addr[31:IndexWidth+2];
  assign w_unused_addr_lsbs = ^instAddr[1:0];

  // A returning word on the lookup cycle blocks the hit, so a fill never races a read.
  assign hit = instEn && (r_state == IDLE) && !memInstOutEn &&
               r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign cacheInst = r_data[w_index];

  assign w_miss = instEn && (r_state == IDLE) && !hit && !flush;
  assign w_fill = (r_state == MISS) && memInstOutEn && !r_drop && !flush;

  assign memReqEn   = r_req_en;
  assign memReqAddr = r_req_addr;

  // Control FSM and valid bits. A flush wins over a same-cycle fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_drop     <= 1'b0;
      r_req_en   <= 1'b0;
      r_req_addr <= '0;
      r_valid    <= '0;
    end else begin
      r_req_en <= 1'b0;
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_fill_index] <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state    <= MISS;
            r_req_en   <= 1'b1;
            r_req_addr <= {instAddr[31:2], 2'b00};
            r_drop     <= 1'b0;
          end
        end
        MISS: begin
          if (flush) begin
            r_drop <= 1'b1;
          end
          if (memInstOutEn) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data storage. These need no reset because the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= memInst;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache. The driver predicts each cycle's outputs from an address-level cache model.
// A monitor compares those predictions against the DUT on the falling clock edge.
module tb_icache;

  localparam int unsigned IW      = 7;
  localparam int unsigned ENTRIES = 1 << IW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instEn = 1'b0;
  logic [31:0] instAddr = '0;
  logic        flush = 1'b0;
  logic        hit;
  logic [31:0] cacheInst;
  logic        memReqEn;
  logic [31:0] memReqAddr;
  logic        memInstOutEn = 1'b0;
  logic [31:0] memInst = '0;

  icache #(.IndexWidth(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instEn       (instEn),
    .instAddr     (instAddr),
    .flush        (flush),
    .hit          (hit),
    .cacheInst    (cacheInst),
    .memReqEn     (memReqEn),
    .memReqAddr   (memReqAddr),
    .memInstOutEn (memInstOutEn),
    .memInst      (memInst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        hit;
    logic [31:0] inst;
    logic        req_en;
    logic [31:0] req_addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Reference model. Each entry remembers the full word address it holds.
  bit          m_valid [ENTRIES];
  logic [31:0] m_addr  [ENTRIES];
  logic [31:0] m_data  [ENTRIES];
  bit          m_miss;
  bit          m_drop;
  bit          m_req_en;
  logic [31:0] m_req_addr;

  function automatic void model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_miss     = 1'b0;
    m_drop     = 1'b0;
    m_req_en   = 1'b0;
    m_req_addr = '0;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Drive one cycle, record the predicted outputs, then advance the model across the next rising edge.
  task automatic cyc(input logic rv, input logic en, input logic [31:0] a,
                     input logic fl, input logic fe, input logic [31:0] fd);
    exp_t        e;
    int          idx;
    int          fidx;
    logic [31:0] wa;
    @(negedge clk);
    rst = rv; instEn = en; instAddr = a; flush = fl; memInstOutEn = fe; memInst = fd;
    if (!rv) model_reset();
    wa  = {a[31:2], 2'b00};
    idx = int'(a[IW+1:2]);
    e.id       = cyc_n;
    e.hit      = en && !m_miss && !fe && m_valid[idx] && (m_addr[idx] == wa);
    e.inst     = m_data[idx];
    e.req_en   = m_req_en;
    e.req_addr = m_req_addr;
    exp_q.push_back(e);
    cyc_n++;
    if (rv) begin
      if (!m_miss) begin
        m_req_en = 1'b0;
        if (en && !e.hit && !fl) begin
          m_miss = 1'b1; m_req_en = 1'b1; m_req_addr = wa; m_drop = 1'b0;
        end
      end else begin
        m_req_en = 1'b0;
        if (fe) begin
          if (!m_drop && !fl) begin
            fidx = int'(m_req_addr[IW+1:2]);
            m_valid[fidx] = 1'b1;
            m_addr[fidx]  = m_req_addr;
            m_data[fidx]  = fd;
          end
          m_miss = 1'b0;
        end
        if (fl) m_drop = 1'b1;
      end
      if (fl) foreach (m_valid[i]) m_valid[i] = 1'b0;
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic lookup(input logic [31:0] a);
    cyc(1'b1, 1'b1, a, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic fill(input logic [31:0] d);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, d);
  endtask

  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d);
    lookup(a);
    idle();
    fill(d);
  endtask

  // Monitor: one prediction per driven cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hit", e.id, {31'b0, hit}, {31'b0, e.hit});
        if (e.hit) check("cacheInst", e.id, cacheInst, e.inst);
        check("memReqEn", e.id, {31'b0, memReqEn}, {31'b0, e.req_en});
        check("memReqAddr", e.id, memReqAddr, e.req_addr);
      end
    end
  end

  initial begin
    logic        rv, en, fl, fe;
    logic [31:0] a;
    model_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    // Cold miss, then a fill, then a hit.
    miss_fill(32'h0000_0000, 32'h0000_0013);
    lookup(32'h0000_0000);
    // Conflict: 0x200 replaces 0x0 at the same index.
    miss_fill(32'h0000_0200, 32'hAAAA_0200);
    lookup(32'h0000_0200);
    lookup(32'h0000_0000);
    idle();
    fill(32'h0000_0013);
    // Flush while a miss is outstanding: the fill is discarded.
    lookup(32'h0000_0004);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    fill(32'h1234_5678);
    lookup(32'h0000_0004);
    idle();
    fill(32'h1234_5678);
    // Flush and fill in the same cycle.
    lookup(32'h0000_0008);
    idle();
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBEEF_0008);
    lookup(32'h0000_0008);
    idle();
    fill(32'hBEEF_0008);
    // Reset while a miss is outstanding, followed by a stray fill.
    lookup(32'h0000_000C);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_000C);
    lookup(32'h0000_000C);
    idle();
    fill(32'h0000_C0C0);
    // Back-to-back hits with a stepping address.
    miss_fill(32'h0000_0000, 32'h0000_0013);
    miss_fill(32'h0000_0004, 32'h0000_0093);
    miss_fill(32'h0000_0008, 32'h0000_0113);
    lookup(32'h0000_0000);
    lookup(32'h0000_0004);
    lookup(32'h0000_0008);
    lookup(32'h0000_0001);
    // Random traffic over a small address pool so hits and conflicts both occur.
    for (int i = 0; i < 3000; i++) begin
      a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 29) == 0);
      fe = m_miss ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      rv = ($urandom_range(0, 199) != 0);
      cyc(rv, en, a, fl, fe, $urandom);
    end
    idle();
    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
